// File: rtl/line_drawer.sv
// Bresenham line rasteriser: walks (x0,y0)->(x1,y1) in any octant and streams one
// coloured pixel per accepted valid/ready handshake to the framebuffer writer.
//
// state | meaning
// IDLE  | waiting for start; busy low
// INIT  | compute deltas, step directions and initial error from latched endpoints
// DRAW  | present current pixel; advance on each accepted handshake
// DONE  | one-cycle done pulse, busy still high; returns to IDLE
module line_drawer #(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] colour_i,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          px_valid,
    input  logic          px_ready,
    output logic [XW-1:0] px_x,
    output logic [YW-1:0] px_y,
    output logic [CW-1:0] px_colour
);

    localparam int MW = (XW > YW) ? XW : YW;
    localparam int EW = MW + 2;

    typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

    state_t               state;
    logic [XW-1:0]        x0_r, x1_r;
    logic [YW-1:0]        y0_r, y1_r;
    logic signed [EW-1:0] dx, dy, err;
    logic                 sx_neg, sy_neg;

    logic signed [EW-1:0] x0_e, x1_e, y0_e, y1_e;
    logic signed [EW-1:0] x_diff, y_diff, dx_init, dy_init;
    logic signed [EW:0]   e2, dx_w, dy_w;
    logic signed [EW-1:0] err_next;
    logic                 step_x, step_y, at_end;
    logic [XW-1:0]        x_next;
    logic [YW-1:0]        y_next;

    assign x0_e = signed'({{(EW-XW){1'b0}}, x0_r});
    assign x1_e = signed'({{(EW-XW){1'b0}}, x1_r});
    assign y0_e = signed'({{(EW-YW){1'b0}}, y0_r});
    assign y1_e = signed'({{(EW-YW){1'b0}}, y1_r});

    always_comb begin
        x_diff  = x1_e - x0_e;
        y_diff  = y1_e - y0_e;
        dx_init = (x_diff < 0) ? -x_diff : x_diff;
        dy_init = (y_diff < 0) ? y_diff : -y_diff;
    end

    // e2 needs one bit beyond err; both step decisions use the same old err.
    always_comb begin
        e2       = {err, 1'b0};
        dx_w     = {dx[EW-1], dx};
        dy_w     = {dy[EW-1], dy};
        at_end   = (px_x == x1_r) && (px_y == y1_r);
        step_x   = (e2 >= dy_w) && (px_x != x1_r);
        step_y   = (e2 <= dx_w) && (px_y != y1_r);
        err_next = err;
        if (step_x) err_next = err_next + dy;
        if (step_y) err_next = err_next + dx;
        x_next   = px_x;
        y_next   = px_y;
        if (step_x) x_next = sx_neg ? px_x - 1'b1 : px_x + 1'b1;
        if (step_y) y_next = sy_neg ? px_y - 1'b1 : px_y + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            px_valid  <= 1'b0;
            px_x      <= '0;
            px_y      <= '0;
            px_colour <= '0;
            x0_r      <= '0;
            x1_r      <= '0;
            y0_r      <= '0;
            y1_r      <= '0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
            sx_neg    <= 1'b0;
            sy_neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x0_r      <= x0;
                        y0_r      <= y0;
                        x1_r      <= x1;
                        y1_r      <= y1;
                        px_colour <= colour_i;
                        busy      <= 1'b1;
                        state     <= INIT;
                    end
                end
                INIT: begin
                    if (abort) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        dx       <= dx_init;
                        dy       <= dy_init;
                        err      <= dx_init + dy_init;
                        sx_neg   <= (x1_r < x0_r);
                        sy_neg   <= (y1_r < y0_r);
                        px_x     <= x0_r;
                        px_y     <= y0_r;
                        px_valid <= 1'b1;
                        state    <= DRAW;
                    end
                end
                DRAW: begin
                    // A final handshake coinciding with abort ends the line the same way.
                    if (abort || (px_ready && at_end)) begin
                        px_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (px_ready) begin
                        err  <= err_next;
                        px_x <= x_next;
                        px_y <= y_next;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    px_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_drawer.sv
// Directed bench for line_drawer: pixel sequences, handshake latency, backpressure,
// abort, command rejection while busy and mid-line reset.
module tb_line_drawer;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset, start, abort, px_ready;
    logic [XW-1:0] x0, x1;
    logic [YW-1:0] y0, y1;
    logic [CW-1:0] colour_i;
    logic          busy, done, px_valid;
    logic [XW-1:0] px_x;
    logic [YW-1:0] px_y;
    logic [CW-1:0] px_colour;

    line_drawer #(.XW(XW), .YW(YW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .colour_i(colour_i), .abort(abort), .busy(busy), .done(done),
        .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
        .px_colour(px_colour)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cap_x[$], cap_y[$], cap_c[$], cap_col[$];
    int done_cnt, done_cyc, stall_bad;
    logic busy_after, done_after;

    task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1, input int col);
        x0 = XW'(ax0); y0 = YW'(ay0); x1 = XW'(ax1); y1 = YW'(ay1);
        colour_i = CW'(col);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records handshakes cycle by cycle (c counts negedges after the start edge).
    task automatic capture(input int mode, input int abort_at, input bit abort_rdy,
                           input int start_at, input int max_cyc);
        logic [XW-1:0] lx;
        logic [YW-1:0] ly;
        logic [CW-1:0] lc;
        bit stalled, aborted, fin;
        stalled = 0; aborted = 0; fin = 0;
        lx = '0; ly = '0; lc = '0;
        cap_x.delete(); cap_y.delete(); cap_c.delete(); cap_col.delete();
        done_cnt = 0; done_cyc = -1; stall_bad = 0; busy_after = 1'b1; done_after = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            if (stalled && (px_valid !== 1'b1 || px_x !== lx || px_y !== ly || px_colour !== lc))
                stall_bad++;
            if (fin) begin
                busy_after = busy;
                done_after = done;
                break;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
                fin = 1;
            end
            px_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            abort = 1'b0;
            start = 1'b0;
            if (!aborted && abort_at >= 0 && px_valid === 1'b1 && cap_x.size() == abort_at) begin
                abort = 1'b1;
                px_ready = abort_rdy;
                aborted = 1;
            end
            if (c == start_at) begin
                start = 1'b1;
                x0 = 10'd500; y0 = 9'd400; x1 = 10'd0; y1 = 9'd0;
                colour_i = 8'h11;
            end
            if (px_valid === 1'b1 && px_ready) begin
                cap_x.push_back(int'(px_x));
                cap_y.push_back(int'(px_y));
                cap_c.push_back(c);
                cap_col.push_back(int'(px_colour));
            end
            stalled = (px_valid === 1'b1) && !px_ready;
            lx = px_x; ly = px_y; lc = px_colour;
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
        px_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; abort = 1'b0; px_ready = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour_i = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (px_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", px_valid); end
        n_cmp++; if (px_x !== '0 || px_y !== '0) begin n_err++; $display("FAIL reset_xy got (%0d,%0d) want (0,0)", px_x, px_y); end
        n_cmp++; if (px_colour !== '0) begin n_err++; $display("FAIL reset_colour got %h want 00", px_colour); end
    endtask

    task automatic test_horizontal;
        start_line(0, 0, 5, 0, 8'hA5);
        capture(0, -1, 1'b0, -1, 40);
        n_cmp++; if (cap_x.size() != 6) begin n_err++; $display("FAIL horiz_count got %0d want 6", cap_x.size()); end
        for (int i = 0; i < 6; i++) begin
            int ax, ay, ac, acol;
            ax = (i < cap_x.size()) ? cap_x[i] : -1;
            ay = (i < cap_y.size()) ? cap_y[i] : -1;
            ac = (i < cap_c.size()) ? cap_c[i] : -1;
            acol = (i < cap_col.size()) ? cap_col[i] : -1;
            n_cmp++;
            if (ax != i || ay != 0 || ac != i + 1 || acol != 'hA5) begin
                n_err++;
                $display("FAIL horiz_px%0d got (%0d,%0d) cyc %0d col %0h want (%0d,0) cyc %0d col a5", i, ax, ay, ac, acol, i, i + 1);
            end
        end
        n_cmp++; if (done_cnt != 1 || done_cyc != 7) begin n_err++; $display("FAIL horiz_done got cnt %0d cyc %0d want 1 at 7", done_cnt, done_cyc); end
        n_cmp++; if (busy_after !== 1'b0 || done_after !== 1'b0) begin n_err++; $display("FAIL horiz_after got busy %b done %b want 0 0", busy_after, done_after); end
    endtask

    task automatic test_point;
        start_line(3, 3, 3, 3, 8'h3C);
        capture(0, -1, 1'b0, -1, 20);
        n_cmp++;
        if (cap_x.size() != 1 || cap_x[0] != 3 || cap_y[0] != 3) begin
            n_err++;
            $display("FAIL point_px got count %0d want one pixel (3,3)", cap_x.size());
        end
        n_cmp++; if (done_cnt != 1 || done_cyc != 2) begin n_err++; $display("FAIL point_done got cnt %0d cyc %0d want 1 at 2", done_cnt, done_cyc); end
        n_cmp++; if (busy_after !== 1'b0) begin n_err++; $display("FAIL point_busy got %b want 0", busy_after); end
    endtask

    task automatic check_seq(input string name, input int n, input int ex_x[16], input int ex_y[16]);
        n_cmp++; if (cap_x.size() != n) begin n_err++; $display("FAIL %s_count got %0d want %0d", name, cap_x.size(), n); end
        for (int i = 0; i < n; i++) begin
            int ax, ay;
            ax = (i < cap_x.size()) ? cap_x[i] : -1;
            ay = (i < cap_y.size()) ? cap_y[i] : -1;
            n_cmp++;
            if (ax != ex_x[i] || ay != ex_y[i]) begin
                n_err++;
                $display("FAIL %s_px%0d got (%0d,%0d) want (%0d,%0d)", name, i, ax, ay, ex_x[i], ex_y[i]);
            end
        end
        n_cmp++; if (done_cnt != 1 || busy_after !== 1'b0) begin n_err++; $display("FAIL %s_done got cnt %0d busy %b want 1 0", name, done_cnt, busy_after); end
    endtask

    task automatic test_steep;
        int ex_x[16] = '{80, 80, 81, 81, 81, 82, 82, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int ex_y[16] = '{60, 61, 62, 63, 64, 65, 66, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        start_line(80, 60, 82, 66, 8'h07);
        capture(0, -1, 1'b0, -1, 40);
        check_seq("steep", 7, ex_x, ex_y);
    endtask

    task automatic test_reverse;
        int ex_x[16] = '{10, 9, 8, 7, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int ex_y[16] = '{10, 9, 9, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        start_line(10, 10, 6, 8, 8'h99);
        capture(0, -1, 1'b0, -1, 40);
        check_seq("reverse", 5, ex_x, ex_y);
    endtask

    task automatic test_backpressure;
        int ex_x[16] = '{80, 80, 81, 81, 81, 82, 82, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int ex_y[16] = '{60, 61, 62, 63, 64, 65, 66, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        start_line(80, 60, 82, 66, 8'h5A);
        capture(1, -1, 1'b0, -1, 200);
        check_seq("stall", 7, ex_x, ex_y);
        n_cmp++; if (stall_bad != 0) begin n_err++; $display("FAIL stall_stable got %0d changes want 0", stall_bad); end
    endtask

    task automatic test_abort;
        start_line(0, 0, 5, 0, 8'h42);
        capture(0, 2, 1'b0, -1, 40);
        n_cmp++; if (cap_x.size() != 2) begin n_err++; $display("FAIL abort_count got %0d want 2", cap_x.size()); end
        n_cmp++; if (done_cnt != 1 || done_cyc != 4) begin n_err++; $display("FAIL abort_done got cnt %0d cyc %0d want 1 at 4", done_cnt, done_cyc); end
        n_cmp++; if (busy_after !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy_after); end
        // abort together with the final handshake keeps the last pixel
        start_line(0, 0, 2, 0, 8'h42);
        capture(0, 2, 1'b1, -1, 40);
        n_cmp++; if (cap_x.size() != 3 || done_cnt != 1) begin n_err++; $display("FAIL abort_final got %0d px %0d done want 3 px 1 done", cap_x.size(), done_cnt); end
    endtask

    task automatic test_start_busy;
        int ex_x[16] = '{10, 9, 8, 7, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int ex_y[16] = '{10, 9, 9, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        start_line(10, 10, 6, 8, 8'h99);
        capture(0, -1, 1'b0, 3, 40);
        check_seq("busy_start", 5, ex_x, ex_y);
        n_cmp++; if (cap_col.size() > 4 && cap_col[4] != 'h99) begin n_err++; $display("FAIL busy_start_col got %0h want 99", cap_col[4]); end
        start_line(10, 10, 6, 8, 8'h99);
        capture(0, -1, 1'b0, 6, 40);
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || px_valid !== 1'b0) begin n_err++; $display("FAIL done_start got busy %b valid %b want 0 0", busy, px_valid); end
    endtask

    task automatic test_reset_mid;
        int bad;
        bad = 0;
        start_line(0, 0, 5, 0, 8'hEE);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || px_valid !== 1'b0 || px_x !== '0 || px_y !== '0 || px_colour !== '0) begin
            n_err++;
            $display("FAIL midreset_out got busy %b done %b valid %b (%0d,%0d) col %h want all 0", busy, done, px_valid, px_x, px_y, px_colour);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done !== 1'b0 || busy !== 1'b0 || px_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL midreset_quiet got %0d active cycles want 0", bad); end
    endtask

    task automatic test_full_range;
        start_line(0, 0, 1023, 511, 8'hFF);
        capture(0, -1, 1'b0, -1, 1100);
        n_cmp++; if (cap_x.size() != 1024) begin n_err++; $display("FAIL full_count got %0d want 1024", cap_x.size()); end
        n_cmp++;
        if (cap_x.size() == 0 || cap_x[cap_x.size()-1] != 1023 || cap_y[cap_y.size()-1] != 511) begin
            n_err++;
            $display("FAIL full_last got count %0d want last pixel (1023,511)", cap_x.size());
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL full_done got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_point();
        test_steep();
        test_reverse();
        test_backpressure();
        test_abort();
        test_start_busy();
        test_reset_mid();
        test_full_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
